// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: purely combinational stall/flush conditions for fetch, data memory, jumps and solo instructions.
// Optional HAZARD_SCAN_EN adds a cycle counter and windowed simulation-only debug printing.
module hazard_detection_unit #(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 20,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_ready,
    input  logic                    fetch_valid,
    input  logic                    issue_request,
    input  logic [ADDRESS_BITS-1:0] issue_PC,
    input  logic [ADDRESS_BITS-1:0] fetch_address_in,
    input  logic                    memory_valid,
    input  logic                    memory_ready,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-1:0] load_address,
    input  logic [ADDRESS_BITS-1:0] memory_address_in,
    input  logic [6:0]              opcode_decode,
    input  logic [6:0]              opcode_execute,
    input  logic                    branch_execute,
    input  logic                    solo_instr_decode,
    input  logic                    solo_instr_execute,
    input  logic                    solo_instr_memory_issue,
    input  logic                    solo_instr_memory_receive,
    input  logic                    solo_instr_writeback,
    output logic                    i_mem_issue_hazard,
    output logic                    i_mem_recv_hazard,
    output logic                    d_mem_issue_hazard,
    output logic                    d_mem_recv_hazard,
    output logic                    JALR_branch_hazard,
    output logic                    JAL_hazard,
    output logic                    solo_instr_hazard,
    input  logic                    scan
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic fetch_addr_match;
    logic load_addr_match;

    assign fetch_addr_match = (fetch_address_in == issue_PC);
    assign load_addr_match  = (memory_address_in == load_address);

    // A valid response tagged for a different address is stale and must not be consumed.
    assign i_mem_issue_hazard = ~fetch_ready;
    assign i_mem_recv_hazard  = issue_request & (~fetch_valid | ~fetch_addr_match);
    assign d_mem_issue_hazard = ~memory_ready & (load_memory | store_memory);
    assign d_mem_recv_hazard  = load_memory & (~memory_valid | ~load_addr_match);

    assign JAL_hazard         = (opcode_decode == OP_JAL);
    assign JALR_branch_hazard = (opcode_execute == OP_JALR) |
                                ((opcode_execute == OP_BRANCH) & branch_execute);

    // A solo instruction in decode waits there; only its presence downstream blocks others.
    assign solo_instr_hazard  = solo_instr_execute | solo_instr_memory_issue |
                                solo_instr_memory_receive | solo_instr_writeback;

    logic unused_ok;

`ifdef HAZARD_SCAN_EN
    logic [31:0] cycle_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (scan && (cycle_count >= 32'(SCAN_CYCLES_MIN)) &&
            (cycle_count <= 32'(SCAN_CYCLES_MAX))) begin
            $display("core %0d hazard unit cycle %0d", CORE, cycle_count);
            $display("  fetch_ready=%b fetch_valid=%b issue_request=%b issue_PC=%h fetch_address_in=%h",
                     fetch_ready, fetch_valid, issue_request, issue_PC, fetch_address_in);
            $display("  memory_valid=%b memory_ready=%b load_memory=%b store_memory=%b load_address=%h memory_address_in=%h",
                     memory_valid, memory_ready, load_memory, store_memory, load_address, memory_address_in);
            $display("  opcode_decode=%b opcode_execute=%b branch_execute=%b",
                     opcode_decode, opcode_execute, branch_execute);
            $display("  solo decode=%b execute=%b mem_issue=%b mem_receive=%b writeback=%b",
                     solo_instr_decode, solo_instr_execute, solo_instr_memory_issue,
                     solo_instr_memory_receive, solo_instr_writeback);
            $display("  i_mem_issue=%b i_mem_recv=%b d_mem_issue=%b d_mem_recv=%b JALR_branch=%b JAL=%b solo=%b",
                     i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
                     JALR_branch_hazard, JAL_hazard, solo_instr_hazard);
        end
    end

    assign unused_ok = solo_instr_decode;
`else
    assign unused_ok = ^{1'b0, clock, reset, scan, solo_instr_decode,
                         CORE[0], SCAN_CYCLES_MIN[0], SCAN_CYCLES_MAX[0]};
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; outputs checked as a 7-bit vector
// {i_mem_issue, i_mem_recv, d_mem_issue, d_mem_recv, JALR_branch, JAL, solo}.
module tb_hazard_detection_unit;
    localparam int AW = 20;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetch_ready, fetch_valid, issue_request;
    logic [AW-1:0] issue_PC, fetch_address_in;
    logic          memory_valid, memory_ready, load_memory, store_memory;
    logic [AW-1:0] load_address, memory_address_in;
    logic [6:0]    opcode_decode, opcode_execute;
    logic          branch_execute;
    logic          solo_instr_decode, solo_instr_execute, solo_instr_memory_issue;
    logic          solo_instr_memory_receive, solo_instr_writeback;
    logic          i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard, d_mem_recv_hazard;
    logic          JALR_branch_hazard, JAL_hazard, solo_instr_hazard;
    logic          scan;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    hazard_detection_unit #(.ADDRESS_BITS(AW)) dut (
        .clock(clock), .reset(reset),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .issue_request(issue_request),
        .issue_PC(issue_PC), .fetch_address_in(fetch_address_in),
        .memory_valid(memory_valid), .memory_ready(memory_ready),
        .load_memory(load_memory), .store_memory(store_memory),
        .load_address(load_address), .memory_address_in(memory_address_in),
        .opcode_decode(opcode_decode), .opcode_execute(opcode_execute),
        .branch_execute(branch_execute),
        .solo_instr_decode(solo_instr_decode), .solo_instr_execute(solo_instr_execute),
        .solo_instr_memory_issue(solo_instr_memory_issue),
        .solo_instr_memory_receive(solo_instr_memory_receive),
        .solo_instr_writeback(solo_instr_writeback),
        .i_mem_issue_hazard(i_mem_issue_hazard), .i_mem_recv_hazard(i_mem_recv_hazard),
        .d_mem_issue_hazard(d_mem_issue_hazard), .d_mem_recv_hazard(d_mem_recv_hazard),
        .JALR_branch_hazard(JALR_branch_hazard), .JAL_hazard(JAL_hazard),
        .solo_instr_hazard(solo_instr_hazard),
        .scan(scan)
    );

    logic [6:0] hz;
    assign hz = {i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
                 JALR_branch_hazard, JAL_hazard, solo_instr_hazard};

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Quiet pipeline: every handshake ready/valid, nothing outstanding, R-type opcodes.
    task automatic idle_inputs();
        fetch_ready = 1'b1; fetch_valid = 1'b1; issue_request = 1'b0;
        issue_PC = '0; fetch_address_in = '0;
        memory_valid = 1'b1; memory_ready = 1'b1; load_memory = 1'b0; store_memory = 1'b0;
        load_address = '0; memory_address_in = '0;
        opcode_decode = R_TYPE; opcode_execute = R_TYPE; branch_execute = 1'b0;
        solo_instr_decode = 1'b0; solo_instr_execute = 1'b0; solo_instr_memory_issue = 1'b0;
        solo_instr_memory_receive = 1'b0; solo_instr_writeback = 1'b0;
    endtask

    task automatic step(input string tag, input logic [6:0] exp);
        @(negedge clock);
        check_val(tag, hz, exp);
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    initial begin
        scan = 1'b0;
        reset = 1'b0;
        idle_inputs();
        step("reset_idle", 7'b0000000);
        fetch_ready = 1'b0;
        step("reset_fetch_stall", 7'b1000000);
        reset = 1'b1;

        step("idle", 7'b0000000);
        issue_request = 1'b1; fetch_valid = 1'b0;
        step("ifetch_not_valid", 7'b0100000);
        issue_request = 1'b1; fetch_address_in = 20'd4; issue_PC = 20'd0;
        step("ifetch_addr_mismatch", 7'b0100000);
        issue_request = 1'b1; fetch_address_in = 20'h00123; issue_PC = 20'h00123;
        step("ifetch_addr_match", 7'b0000000);
        issue_request = 1'b1; fetch_address_in = 20'h80000; issue_PC = 20'h00000;
        step("ifetch_msb_mismatch", 7'b0100000);
        fetch_ready = 1'b0;
        step("ifetch_not_ready", 7'b1000000);

        store_memory = 1'b1; memory_ready = 1'b0;
        step("store_not_ready", 7'b0010000);
        store_memory = 1'b1; memory_valid = 1'b0;
        step("store_no_recv_hz", 7'b0000000);
        memory_ready = 1'b0;
        step("not_ready_no_req", 7'b0000000);
        load_memory = 1'b1; memory_valid = 1'b0;
        step("load_not_valid", 7'b0001000);
        load_memory = 1'b1; load_address = 20'hABCDE; memory_address_in = 20'hABCDE;
        step("load_addr_match", 7'b0000000);
        load_memory = 1'b1; load_address = 20'h00001; memory_address_in = 20'h80001;
        step("load_msb_mismatch", 7'b0001000);

        opcode_decode = JAL;
        step("jal_decode", 7'b0000010);
        opcode_execute = JAL;
        step("jal_in_execute", 7'b0000000);
        opcode_execute = JALR;
        step("jalr_execute", 7'b0000100);
        opcode_decode = JALR;
        step("jalr_in_decode", 7'b0000000);
        opcode_execute = BRANCH; branch_execute = 1'b0;
        step("branch_not_taken", 7'b0000000);
        opcode_execute = BRANCH; branch_execute = 1'b1;
        step("branch_taken", 7'b0000100);
        branch_execute = 1'b1;
        step("taken_flag_rtype", 7'b0000000);

        solo_instr_execute = 1'b1;
        step("solo_execute", 7'b0000001);
        solo_instr_decode = 1'b1;
        step("solo_decode_only", 7'b0000000);
        solo_instr_memory_issue = 1'b1;
        step("solo_mem_issue", 7'b0000001);
        solo_instr_memory_receive = 1'b1;
        step("solo_mem_recv", 7'b0000001);
        solo_instr_writeback = 1'b1;
        step("solo_writeback", 7'b0000001);

        fetch_ready = 1'b0; issue_request = 1'b1; fetch_valid = 1'b0;
        store_memory = 1'b1; load_memory = 1'b1; memory_ready = 1'b0; memory_valid = 1'b0;
        opcode_decode = JAL; opcode_execute = JALR; solo_instr_writeback = 1'b1;
        step("all_at_once", 7'b1111111);

        scan = 1'b1;
        opcode_decode = JAL;
        step("scan_no_effect", 7'b0000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter CORE, default 0, core index printed in scan output.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20, width of all address/PC ports.
REQ-003 SHALL have parameter SCAN_CYCLES_MIN, default 0, first cycle count at which scan printing is allowed.
REQ-004 SHALL have parameter SCAN_CYCLES_MAX, default 1000, last cycle count at which scan printing is allowed.
REQ-005 SHALL have ports, one per line:
- clock in 1: sole clock, rising edge.
- reset in 1: synchronous, active-low reset.
- fetch_ready in 1: instruction memory accepts a request.
- fetch_valid in 1: instruction memory response valid.
- issue_request in 1: an instruction fetch is outstanding.
- issue_PC in ADDRESS_BITS: PC of the outstanding fetch.
- fetch_address_in in ADDRESS_BITS: address tag of the instruction response.
- memory_valid in 1: data memory response valid.
- memory_ready in 1: data memory accepts a request.
- load_memory in 1: load awaiting data.
- store_memory in 1: store awaiting issue.
- load_address in ADDRESS_BITS: address of the pending load.
- memory_address_in in ADDRESS_BITS: address tag of the data response.
- opcode_decode in 7: decode-stage opcode.
- opcode_execute in 7: execute-stage opcode.
- branch_execute in 1: execute-stage branch taken.
- solo_instr_decode in 1: solo instruction in decode.
- solo_instr_execute in 1: solo instruction in execute.
- solo_instr_memory_issue in 1: solo instruction in memory issue.
- solo_instr_memory_receive in 1: solo instruction in memory receive.
- solo_instr_writeback in 1: solo instruction in writeback.
- i_mem_issue_hazard out 1; i_mem_recv_hazard out 1; d_mem_issue_hazard out 1; d_mem_recv_hazard out 1; JALR_branch_hazard out 1; JAL_hazard out 1; solo_instr_hazard out 1.
- scan in 1: enables debug printing.

Function
REQ-006 All hazard outputs SHALL be purely combinational, zero-cycle latency, not gated by reset.
REQ-007 i_mem_issue_hazard SHALL equal ~fetch_ready.
REQ-008 i_mem_recv_hazard SHALL equal issue_request & (~fetch_valid | (fetch_address_in != issue_PC)); a valid response with mismatched address is a hazard.
REQ-009 d_mem_issue_hazard SHALL equal ~memory_ready & (load_memory | store_memory).
REQ-010 d_mem_recv_hazard SHALL equal load_memory & (~memory_valid | (memory_address_in != load_address)); stores never raise it.
REQ-011 JAL_hazard SHALL be 1 iff opcode_decode == 7'b1101111.
REQ-012 JALR_branch_hazard SHALL be 1 iff opcode_execute == 7'b1100111, or opcode_execute == 7'b1100011 and branch_execute == 1; untaken branch SHALL give 0.
REQ-013 solo_instr_hazard SHALL be the OR of solo_instr_execute, solo_instr_memory_issue, solo_instr_memory_receive, solo_instr_writeback; solo_instr_decode SHALL NOT affect it.
REQ-014 Address compares SHALL use the full ADDRESS_BITS width; simultaneous hazards SHALL all assert independently.

Reset
REQ-015 On a rising clock edge with reset == 0, the scan cycle counter SHALL load 0.
REQ-016 Hazard outputs SHALL follow REQ-007..013 during and after reset.

Configuration
REQ-017 Macro HAZARD_SCAN_EN: when defined, a 32-bit cycle counter SHALL increment on every non-reset rising edge, and when scan == 1 with SCAN_CYCLES_MIN <= counter <= SCAN_CYCLES_MAX the block SHALL print CORE, the counter, all inputs and all hazard outputs once per cycle (simulation only).
REQ-018 Without HAZARD_SCAN_EN, the counter and printing SHALL be absent, scan SHALL be ignored, and hazard outputs SHALL be unchanged.

Verification
REQ-019 All ready/valid=1, requests 0, opcodes R-type 7'b0110011 -> all hazard outputs 0.
REQ-020 issue_request=1, fetch_valid=0 -> i_mem_recv_hazard=1, others 0; then fetch_valid=1, fetch_address_in=4, issue_PC=0 -> i_mem_recv_hazard stays 1.
REQ-021 store_memory=1, memory_ready=0 -> d_mem_issue_hazard=1 only; load_memory=1, memory_ready=1, memory_valid=0 -> d_mem_recv_hazard=1 only.
REQ-022 opcode_decode=JAL -> JAL_hazard=1 only; opcode_execute=JALR -> JALR_branch_hazard=1 only; BRANCH with branch_execute=0 -> all 0; with branch_execute=1 -> JALR_branch_hazard=1.
REQ-023 solo_instr_execute=1, all else clear -> solo_instr_hazard=1, other hazards 0.
